// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter slice.
// Register/data widths, the x0 encoding and the FIFO entry layout.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << REG_W;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // One-hot mask for a register index; x0 never maps to a bit.
    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] r);
        logic [NREGS-1:0] m;
        m = '0;
        if (r != REG_ZERO) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO for the multi-cycle unit (DEPTH x wb_entry_t).
// Ports: clk2, reset (async low), push/din, pop/dout (head), count, empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk2,
    input  logic          reset,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: stale words are never visible
    // because the pointers and count are cleared.
    always_ff @(posedge clk2) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. queued multi-cycle results.
// Ports: clk2/reset, wb_* primary, md_* multi-cycle, RegWrite/Write_*, pending, fifo_count, err.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk2,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              md_issue,
    input  logic [REG_W-1:0]  md_issue_reg,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              RegWrite,
    output logic [REG_W-1:0]  Write_register,
    output logic [DATA_W-1:0] Write_data,
    output logic [NREGS-1:0]  pending,
    output logic [CW-1:0]     fifo_count,
    output logic              err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t        md_entry;
    wb_entry_t        head;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             drain;
    logic             wb_req;
    logic             prim_go;
    logic             issue;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] pending_next;
    logic             err_ovf;
    logic             err_dup;
    logic             err_orphan;

    // x0 results are accepted but never queued.
    assign md_entry  = '{rd: md_reg, data: md_data};
    assign md_ready  = (fifo_count < FULL_CNT);
    assign fifo_push = md_valid && md_ready && (md_reg != REG_ZERO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk2  (clk2),
        .reset (reset),
        .push  (fifo_push),
        .din   (md_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // A full FIFO takes the port for one cycle; the pop drops
    // the count below DEPTH, so the stall never lasts longer.
    always_comb begin
        drain    = (fifo_count == FULL_CNT);
        wb_req   = wb_valid && (wb_reg != REG_ZERO);
        prim_go  = wb_req && !drain;
        fifo_pop = !fifo_empty && (drain || !wb_req);
        wb_stall = drain && wb_req;
        issue    = prim_go || fifo_pop;
    end

    // Set beats clear when both hit the same register.
    always_comb begin
        set_mask     = '0;
        clr_mask     = '0;
        if (md_issue) begin
            set_mask = reg_mask(md_issue_reg);
        end
        if (fifo_pop) begin
            clr_mask = reg_mask(head.rd);
        end
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_comb begin
        err_ovf    = md_valid && !md_ready;
        err_dup    = md_issue && (md_issue_reg != REG_ZERO)
                     && pending[md_issue_reg];
        err_orphan = fifo_pop && !pending[head.rd];
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            RegWrite       <= 1'b0;
            Write_register <= REG_ZERO;
            Write_data     <= '0;
        end else begin
            RegWrite <= issue;
            if (prim_go) begin
                Write_register <= wb_reg;
                Write_data     <= wb_data;
            end else if (fifo_pop) begin
                Write_register <= head.rd;
                Write_data     <= head.data;
            end
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_next;
            if (err_ovf || err_dup || err_orphan) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter (DEPTH=4).
// Vector table for primary writes, scoreboard queue for every register-file write.
module tb_wb_write_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk2;
    logic              reset;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;
    logic              md_issue;
    logic [REG_W-1:0]  md_issue_reg;
    logic              md_valid;
    logic [REG_W-1:0]  md_reg;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic              RegWrite;
    logic [REG_W-1:0]  Write_register;
    logic [DATA_W-1:0] Write_data;
    logic [NREGS-1:0]  pending;
    logic [CW-1:0]     fifo_count;
    logic              err;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk2           (clk2),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .wb_stall       (wb_stall),
        .md_issue       (md_issue),
        .md_issue_reg   (md_issue_reg),
        .md_valid       (md_valid),
        .md_reg         (md_reg),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .pending        (pending),
        .fifo_count     (fifo_count),
        .err            (err)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    exp_t q[$];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic expect_wr(input int r, input logic [31:0] d);
        exp_t e;
        e.r = 5'(r);
        e.d = d;
        q.push_back(e);
    endtask

    // Advance one edge; any write the DUT issued must match the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk2);
        #1;
        if (RegWrite === 1'b1) begin
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL sb_unexpected: got write r%0d 0x%08h expected none",
                         Write_register, Write_data);
            end else begin
                e = q.pop_front();
                chk("sb_reg", 32'(Write_register), 32'(e.r));
                chk("sb_data", Write_data, e.d);
            end
        end
    endtask

    task automatic idle_inputs();
        wb_valid     = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        md_issue     = 1'b0;
        md_issue_reg = '0;
        md_valid     = 1'b0;
        md_reg       = '0;
        md_data      = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
        chk({tag, "_wreg"}, 32'(Write_register), 32'd0);
        chk({tag, "_wdata"}, Write_data, 32'd0);
        chk({tag, "_pending"}, pending, 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_stall"}, 32'(wb_stall), 32'd0);
        chk({tag, "_ready"}, 32'(md_ready), 32'd1);
    endtask

    vec_t vecs[6];
    int   mregs[3];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h1111_1111, 1'b0, 5'd5,  32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 1'b1, 5'd31, 32'hA5A5_5A5A};
        vecs[3] = '{1'b0, 5'd12, 32'h2222_2222, 1'b0, 5'd31, 32'hA5A5_5A5A};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
        vecs[5] = '{1'b1, 5'd17, 32'hFFFF_FFFF, 1'b1, 5'd17, 32'hFFFF_FFFF};

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk2);
        #1;
        check_reset_state("rst");
        reset = 1'b1;
        tick();

        // Primary writes from the vector table.
        foreach (vecs[i]) begin
            wb_valid = vecs[i].wv;
            wb_reg   = vecs[i].wr;
            wb_data  = vecs[i].wd;
            #1;
            chk("vec_stall", 32'(wb_stall), 32'd0);
            if (vecs[i].exp_we) begin
                expect_wr(int'(vecs[i].exp_reg), vecs[i].exp_data);
            end
            tick();
            chk("vec_we", 32'(RegWrite), 32'(vecs[i].exp_we));
            chk("vec_reg", 32'(Write_register), 32'(vecs[i].exp_reg));
            chk("vec_data", Write_data, vecs[i].exp_data);
        end
        idle_inputs();
        tick();
        chk("idle_we", 32'(RegWrite), 32'd0);

        // Multi-cycle result with no competing primary.
        md_issue     = 1'b1;
        md_issue_reg = 5'd8;
        tick();
        idle_inputs();
        chk("mc_pending_set", pending, 32'h0000_0100);
        repeat (5) tick();
        md_valid = 1'b1;
        md_reg   = 5'd8;
        md_data  = 32'h0000_1234;
        expect_wr(8, 32'h0000_1234);
        tick();
        idle_inputs();
        chk("mc_push_we", 32'(RegWrite), 32'd0);
        chk("mc_count1", 32'(fifo_count), 32'd1);
        tick();
        chk("mc_issue_we", 32'(RegWrite), 32'd1);
        chk("mc_pending_clr", pending, 32'd0);
        chk("mc_count0", 32'(fifo_count), 32'd0);

        // Contention: primary held while four results fill the FIFO.
        for (int i = 0; i < 4; i++) begin
            md_issue     = 1'b1;
            md_issue_reg = 5'(10 + i);
            tick();
        end
        md_issue = 1'b0;
        chk("ct_pending", pending, 32'h0000_3C00);
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1;
            wb_reg   = 5'd7;
            wb_data  = 32'h7000_0000 + 32'(i);
            md_valid = 1'b1;
            md_reg   = 5'(10 + i);
            md_data  = 32'hA0 + 32'(i);
            expect_wr(7, wb_data);
            tick();
        end
        md_valid = 1'b0;
        wb_data  = 32'h7000_0004;
        #1;
        chk("ct_count_full", 32'(fifo_count), 32'd4);
        chk("ct_ready0", 32'(md_ready), 32'd0);
        chk("ct_stall1", 32'(wb_stall), 32'd1);
        expect_wr(10, 32'hA0);
        tick();
        chk("ct_stall0", 32'(wb_stall), 32'd0);
        chk("ct_count3", 32'(fifo_count), 32'd3);
        expect_wr(7, 32'h7000_0004);
        tick();
        idle_inputs();
        for (int i = 1; i < 4; i++) begin
            expect_wr(10 + i, 32'hA0 + 32'(i));
        end
        repeat (3) tick();
        chk("ct_count_end", 32'(fifo_count), 32'd0);
        chk("ct_pending_end", pending, 32'd0);
        chk("ct_err", 32'(err), 32'd0);

        // Overflow: result offered while full is dropped and flagged.
        for (int i = 0; i < 4; i++) begin
            md_issue     = 1'b1;
            md_issue_reg = 5'(20 + i);
            tick();
        end
        md_issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1;
            wb_reg   = 5'd7;
            wb_data  = 32'h7100_0000 + 32'(i);
            md_valid = 1'b1;
            md_reg   = 5'(20 + i);
            md_data  = 32'hB0 + 32'(i);
            expect_wr(7, wb_data);
            tick();
        end
        wb_valid = 1'b0;
        md_valid = 1'b1;
        md_reg   = 5'd24;
        md_data  = 32'h0000_0BAD;
        #1;
        chk("ov_ready0", 32'(md_ready), 32'd0);
        expect_wr(20, 32'hB0);
        tick();
        idle_inputs();
        chk("ov_err", 32'(err), 32'd1);
        chk("ov_count3", 32'(fifo_count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            expect_wr(20 + i, 32'hB0 + 32'(i));
        end
        repeat (3) tick();
        chk("ov_count0", 32'(fifo_count), 32'd0);

        // Reset mid-stream with three queued results.
        mregs = '{2, 8, 8};
        md_issue     = 1'b1;
        md_issue_reg = 5'd2;
        tick();
        md_issue_reg = 5'd8;
        tick();
        md_issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1;
            wb_reg   = 5'd7;
            wb_data  = 32'h7200_0000 + 32'(i);
            md_valid = 1'b1;
            md_reg   = 5'(mregs[i]);
            md_data  = 32'hC0 + 32'(i);
            expect_wr(7, wb_data);
            tick();
        end
        idle_inputs();
        chk("rm_count3", 32'(fifo_count), 32'd3);
        chk("rm_pending", pending, 32'h0000_0104);
        reset = 1'b0;
        #1;
        check_reset_state("rm");
        tick();
        reset = 1'b1;
        tick();

        // Issuing to an already-pending register.
        md_issue     = 1'b1;
        md_issue_reg = 5'd3;
        tick();
        chk("dup_err0", 32'(err), 32'd0);
        tick();
        idle_inputs();
        chk("dup_err1", 32'(err), 32'd1);
        chk("dup_pending", pending, 32'h0000_0008);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Same-cycle set and clear of reg 9: set wins.
        md_issue     = 1'b1;
        md_issue_reg = 5'd9;
        tick();
        idle_inputs();
        md_valid = 1'b1;
        md_reg   = 5'd9;
        md_data  = 32'h0000_0099;
        expect_wr(9, 32'h0000_0099);
        tick();
        idle_inputs();
        md_issue     = 1'b1;
        md_issue_reg = 5'd9;
        tick();
        idle_inputs();
        chk("sc_we", 32'(RegWrite), 32'd1);
        chk("sc_pending9", pending, 32'h0000_0200);
        chk("sc_err", 32'(err), 32'd1);

        tick();
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
